pit_ctrl: RTL

PIT_CTRL -- requirements
Module: pit_ctrl

---
 rtl/pit_ctrl_if.sv | 25 ++
 rtl/pit_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pit_ctrl_if.sv
// AXI-lite write-channel bundle between pit_ctrl (master) and the PIT register slave.
interface pit_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/pit_ctrl.sv
// Programs a PIT through an AXI-lite write master on start/stop pulses and counts PIT interrupt edges.
// Defining PIT_CTRL_TIMEOUT_EN adds a B-response timeout of TIMEOUT_CYCLES cycles.
module pit_ctrl #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CTRL_ADDR          = 4'h0,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] PERIOD_ADDR        = 4'h4,
  parameter int unsigned                   TIMEOUT_CYCLES     = 256
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period,
  input  logic        irq_in,
  output logic        busy,
  output logic        running,
  output logic        err,
  output logic [31:0] tick_count,
  pit_ctrl_if.master  m_axi
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEQ_PERIOD = 2'd0,
    SEQ_ENABLE = 2'd1,
    SEQ_STOP   = 2'd2
  } seq_t;

  // Control word: bit0 enable, bit1 irq enable, bit2 auto-reload.
  localparam logic [31:0] CTRL_ENABLE  = 32'h0000_0007;
  localparam logic [31:0] CTRL_DISABLE = 32'h0000_0000;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pit_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                        state_q;
  seq_t                          seq_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          aw_done_q;
  logic                          w_done_q;
  logic                          bready_q;
  logic                          busy_q;
  logic                          running_q;
  logic                          err_q;
  logic                          stop_pend_q;
  logic                          irq_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]                   wdata_q;
  logic [31:0]                   tick_q;

  logic        aw_fire;
  logic        w_fire;
  logic        aw_ok_d;
  logic        w_ok_d;
  logic        irq_rise;
  logic        timeout_d;
  logic [31:0] tick_d;

  assign aw_fire  = awvalid_q & m_axi.awready;
  assign w_fire   = wvalid_q & m_axi.wready;
  assign aw_ok_d  = aw_done_q | aw_fire;
  assign w_ok_d   = w_done_q | w_fire;
  assign irq_rise = irq_in & ~irq_q;
  assign tick_d   = (running_q && irq_rise) ? tick_q + 32'd1 : tick_q;

`ifdef PIT_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  assign timeout_d = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in RESP without bvalid; zero on every entry to RESP.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      to_cnt_q <= '0;
    end else if (state_q != RESP) begin
      to_cnt_q <= '0;
    end else if (!m_axi.bvalid) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q     <= IDLE;
      seq_q       <= SEQ_PERIOD;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      irq_q       <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      tick_q      <= '0;
    end else begin
      irq_q  <= irq_in;
      tick_q <= tick_d;

      // A stop that arrives mid-sequence is remembered and replayed from IDLE.
      if (stop && state_q != IDLE) begin
        stop_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (stop || stop_pend_q) begin
            stop_pend_q <= 1'b0;
            seq_q       <= SEQ_STOP;
            awaddr_q    <= CTRL_ADDR;
            wdata_q     <= CTRL_DISABLE;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ADDR_DATA;
          end else if (start) begin
            if (period == 32'd0) begin
              err_q <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              tick_q    <= '0;
              seq_q     <= SEQ_PERIOD;
              awaddr_q  <= PERIOD_ADDR;
              wdata_q   <= period;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ADDR_DATA;
            end
          end
        end

        ADDR_DATA: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok_d && w_ok_d) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end

        RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp != 2'b00) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              case (seq_q)
                SEQ_PERIOD: begin
                  seq_q     <= SEQ_ENABLE;
                  awaddr_q  <= CTRL_ADDR;
                  wdata_q   <= CTRL_ENABLE;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  state_q   <= ADDR_DATA;
                end
                SEQ_ENABLE: begin
                  running_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
                end
                default: begin
                  running_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
                end
              endcase
            end
          end else if (timeout_d) begin
            err_q    <= 1'b1;
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.bready  = bready_q;

  assign busy       = busy_q;
  assign running    = running_q;
  assign err        = err_q;
  assign tick_count = tick_q;

endmodule
